// File: rtl/spmv_csr_mac_engine_if.sv
// Nonzero-pair stream into the CSR SpMV engine: one (a, x) pair per valid/ready transfer.
// The master drives the pair, the engine (slave) returns ready.
interface spmv_csr_mac_engine_if #(
  parameter int DATA_W = 16
);
  logic                     valid;
  logic                     ready;
  logic signed [DATA_W-1:0] a;
  logic signed [DATA_W-1:0] x;

  modport master (output valid, output a, output x, input ready);
  modport slave  (input valid, input a, input x, output ready);
endinterface

// File: rtl/spmv_csr_mac_engine.sv
// CSR sparse-matrix x dense-vector engine with a 2-stage signed multiply-accumulate.
// Define SPMV_SATURATE_EN for saturating accumulation; the default build wraps at ACC_W.
//
// state | meaning
// IDLE  | waiting for i_start; row_ptr latched and results cleared on start
// RUN   | accepting (a, x) pairs in CSR nonzero order
// DRAIN | last pair's accumulate in flight, no new pairs
// DONE  | o_done pulse, results final
module spmv_csr_mac_engine #(
  parameter int NUM_ROWS = 16,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 32,
  parameter int PTR_W    = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [(NUM_ROWS+1)*PTR_W-1:0] i_row_ptr,
  spmv_csr_mac_engine_if.slave          s_pair,
  output logic [1:0]                    o_state,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [NUM_ROWS*ACC_W-1:0]     o_result
);
  localparam int TAG_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [PTR_W-1:0]        row_ptr [NUM_ROWS+1];
  logic [PTR_W-1:0]        k;
  logic [PTR_W-1:0]        nnz_in;
  logic                    ready;
  logic                    fire;
  logic                    last;
  logic                    start_ok;
  logic [TAG_W-1:0]        tag;
  logic signed [2*DATA_W-1:0] prod;
  logic                    s1_valid;
  logic [TAG_W-1:0]        s1_tag;
  logic signed [ACC_W-1:0] s1_prod;
  logic signed [ACC_W-1:0] result [NUM_ROWS];
  logic signed [ACC_W-1:0] acc_sum;

  assign nnz_in   = i_row_ptr[NUM_ROWS*PTR_W +: PTR_W];
  assign start_ok = (state == IDLE) && i_start;
  assign fire     = (state == RUN) && s_pair.valid;
  assign last     = (k == row_ptr[NUM_ROWS] - PTR_W'(1));
  assign prod     = $signed(s_pair.a) * $signed(s_pair.x);
  assign s_pair.ready = ready;

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_nxt = (nnz_in == '0) ? DONE : RUN;
      end
      RUN: begin
        ready  = 1'b1;
        o_busy = 1'b1;
        if (fire && last) state_nxt = DRAIN;
      end
      DRAIN: begin
        o_busy    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Empty rows have row_ptr[r] == row_ptr[r+1] and can never match.
  always_comb begin
    tag = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if ((row_ptr[r] <= k) && (k < row_ptr[r+1])) tag = TAG_W'(r);
    end
  end

`ifdef SPMV_SATURATE_EN
  logic signed [ACC_W:0] sum_wide;
  always_comb begin
    sum_wide = {result[s1_tag][ACC_W-1], result[s1_tag]} + {s1_prod[ACC_W-1], s1_prod};
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1])
      acc_sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_sum = sum_wide[ACC_W-1:0];
  end
`else
  assign acc_sum = result[s1_tag] + s1_prod;
`endif

  // Stage 2 reads the result register directly, so back-to-back hits on one row
  // always see the previous write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      k        <= '0;
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s1_prod  <= '0;
      for (int r = 0; r <= NUM_ROWS; r++) row_ptr[r] <= '0;
      for (int r = 0; r < NUM_ROWS; r++) result[r] <= '0;
    end else begin
      state    <= state_nxt;
      s1_valid <= fire;
      if (fire) begin
        s1_tag  <= tag;
        s1_prod <= ACC_W'(prod);
        k       <= k + PTR_W'(1);
      end
      if (start_ok) begin
        k <= '0;
        for (int r = 0; r <= NUM_ROWS; r++) row_ptr[r] <= i_row_ptr[r*PTR_W +: PTR_W];
        for (int r = 0; r < NUM_ROWS; r++) result[r] <= '0;
      end else if (s1_valid) begin
        result[s1_tag] <= acc_sum;
      end
    end
  end

  assign o_state = state;

  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_result
    assign o_result[g*ACC_W +: ACC_W] = result[g];
  end
endmodule

// File: tb/tb_spmv_csr_mac_engine.sv
// Directed bench for spmv_csr_mac_engine: hand-computed CSR results, handshake and FSM checks.
// Build with SPMV_SATURATE_EN to expect the clamped overflow result.
module tb_spmv_csr_mac_engine;
  localparam int NR = 16;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int PW = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [(NR+1)*PW-1:0]   row_ptr_bus = '0;
  logic [1:0]             state;
  logic                   busy;
  logic                   done;
  logic [NR*AW-1:0]       result;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int ready_cnt = 0;
  int d0, rc0;

  logic [AW-1:0] exp_r [NR];
  int pa [6] = '{3, -2, 1, 7, 2, -4};
  int px [6] = '{4, 5, 1, -1, 2, -4};

  spmv_csr_mac_engine_if #(.DATA_W(DW)) bus ();

  spmv_csr_mac_engine #(
    .NUM_ROWS(NR), .DATA_W(DW), .ACC_W(AW), .PTR_W(PW)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_row_ptr(row_ptr_bus),
    .s_pair   (bus.slave),
    .o_state  (state),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_cnt++;
    if (bus.ready) ready_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_results(input string tag);
    for (int r = 0; r < NR; r++)
      chk($sformatf("%s_r%0d", tag, r), result[r*AW +: AW], exp_r[r]);
  endtask

  task automatic exp_clear();
    for (int r = 0; r < NR; r++) exp_r[r] = '0;
  endtask

  task automatic exp_default();
    exp_clear();
    exp_r[0] = 32'd2;
    exp_r[2] = 32'hFFFF_FFFE;
    exp_r[3] = 32'd16;
  endtask

  // row_ptr = {0,2,2,5,6,6,...}
  task automatic rp_default();
    for (int i = 0; i <= NR; i++)
      row_ptr_bus[i*PW +: PW] = (i == 0) ? 8'd0 : (i <= 2) ? 8'd2 : (i == 3) ? 8'd5 : 8'd6;
  endtask

  task automatic rp_first_row(input logic [PW-1:0] n);
    for (int i = 0; i <= NR; i++)
      row_ptr_bus[i*PW +: PW] = (i == 0) ? 8'd0 : n;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push(input int a, input int x);
    bus.valid = 1'b1;
    bus.a = 16'(a);
    bus.x = 16'(x);
    @(posedge clk); @(negedge clk);
    bus.valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    bus.valid = 1'b0;
    bus.a = '0;
    bus.x = '0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    exp_clear();
    check_results("rst");
    rst = 1'b0;
    @(negedge clk);

    // default matrix, continuous stream
    rp_default();
    d0 = done_cnt;
    pulse_start();
    chk("run_state", 32'(state), 32'd1);
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_ready", 32'(bus.ready), 32'd1);
    push(pa[0], px[0]);
    chk("lat_early_r0", result[0 +: AW], 32'd0);
    push(pa[1], px[1]);
    chk("lat_r0", result[0 +: AW], 32'd12);
    for (int i = 2; i < 6; i++) push(pa[i], px[i]);
    chk("drain_state", 32'(state), 32'd2);
    chk("drain_ready", 32'(bus.ready), 32'd0);
    chk("drain_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("done_state", 32'(state), 32'd3);
    chk("done_pulse", 32'(done), 32'd1);
    exp_default();
    check_results("dflt");
    @(negedge clk);
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("dflt_done_once", 32'(done_cnt - d0), 32'd1);

    // nnz == 0
    rp_first_row(8'd0);
    d0 = done_cnt;
    rc0 = ready_cnt;
    pulse_start();
    chk("nnz0_state", 32'(state), 32'd3);
    chk("nnz0_done", 32'(done), 32'd1);
    exp_clear();
    check_results("nnz0");
    @(negedge clk);
    chk("nnz0_idle", 32'(state), 32'd0);
    chk("nnz0_ready_never", 32'(ready_cnt - rc0), 32'd0);
    chk("nnz0_done_once", 32'(done_cnt - d0), 32'd1);

    // gapped stream; valid held high with junk outside RUN
    rp_default();
    bus.valid = 1'b1; bus.a = 16'd100; bus.x = 16'd100;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      push(pa[i], px[i]);
      bus.a = 16'd9; bus.x = 16'd9;
      @(posedge clk); @(negedge clk);
    end
    bus.valid = 1'b1; bus.a = 16'd100; bus.x = 16'd100;
    wait_done("gap_done");
    exp_default();
    check_results("gap");
    repeat (2) @(negedge clk);
    chk("gap_idle_r0", result[0 +: AW], 32'd2);
    chk("gap_idle_r3", result[3*AW +: AW], 32'd16);
    bus.valid = 1'b0;

    // reset mid-operation, then a single nonzero in row 0
    rp_default();
    pulse_start();
    for (int i = 0; i < 3; i++) push(pa[i], px[i]);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    exp_clear();
    check_results("mid_rst");
    rp_first_row(8'd1);
    pulse_start();
    push(5, 5);
    chk("one_nz_drain", 32'(state), 32'd2);
    wait_done("one_nz_done");
    exp_clear();
    exp_r[0] = 32'd25;
    check_results("one_nz");
    @(negedge clk);

    // overflow: 3 x 32767*32767 into row 0
    rp_first_row(8'd3);
    pulse_start();
    for (int i = 0; i < 3; i++) push(32767, 32767);
    wait_done("ovf_done");
`ifdef SPMV_SATURATE_EN
    chk("ovf_r0", result[0 +: AW], 32'h7FFF_FFFF);
`else
    chk("ovf_r0", result[0 +: AW], 32'hBFFD_0003);
`endif
    chk("ovf_r1", result[AW +: AW], 32'd0);
    @(negedge clk);

    // start during RUN is ignored and row_ptr is not re-latched
    rp_default();
    pulse_start();
    push(pa[0], px[0]);
    push(pa[1], px[1]);
    start = 1'b1;
    row_ptr_bus = '1;
    push(pa[2], px[2]);
    start = 1'b0;
    chk("restart_state", 32'(state), 32'd1);
    for (int i = 3; i < 6; i++) push(pa[i], px[i]);
    wait_done("restart_done");
    exp_default();
    check_results("restart");
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
